// File: rtl/uv_index_sequencer.sv
// (u, v) coefficient index generator for one BLOCK_SIZE x BLOCK_SIZE transform block.
// v is the fast index; done is sticky until restart or rst.
module uv_index_sequencer #(
    parameter int BLOCK_SIZE = 8,
    parameter int IDX_W      = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             restart,
    input  logic             go,
    output logic [IDX_W-1:0] u,
    output logic [IDX_W-1:0] v,
    output logic             last,
    output logic             done
);

    localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(BLOCK_SIZE - 1);

    logic [IDX_W-1:0] u_q, u_d;
    logic [IDX_W-1:0] v_q, v_d;
    logic             done_q, done_d;
    logic             en;

    // One shared enable: restart always loads, go only loads while armed.
    always_comb begin
        en     = restart | (go & ~done_q);
        u_d    = u_q;
        v_d    = v_q;
        done_d = done_q;
        if (restart) begin
            u_d    = '0;
            v_d    = '0;
            done_d = 1'b0;
        end else if (go && !done_q) begin
            if (v_q != MAX_IDX) begin
                v_d = v_q + IDX_W'(1);
            end else if (u_q != MAX_IDX) begin
                v_d = '0;
                u_d = u_q + IDX_W'(1);
            end else begin
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            u_q    <= '0;
            v_q    <= '0;
            done_q <= 1'b0;
        end else if (en) begin
            u_q    <= u_d;
            v_q    <= v_d;
            done_q <= done_d;
        end
    end

    assign u    = u_q;
    assign v    = v_q;
    assign done = done_q;
    assign last = (u_q == MAX_IDX) && (v_q == MAX_IDX) && !done_q;

endmodule

// File: tb/tb_uv_index_sequencer.sv
// Scoreboard bench: drives N=8 and N=4 sequencers with directed and random
// stimulus and compares them against a position-count reference model.
module tb_uv_index_sequencer;

    typedef struct {
        int u;
        int v;
        bit done;
        bit last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic restart = 1'b0;
    logic go = 1'b0;

    logic [2:0] u8, v8;
    logic       last8, done8;
    logic [1:0] u4, v4;
    logic       last4, done4;

    int test_cnt = 0;
    int fail_cnt = 0;

    exp_t q8[$];
    exp_t q4[$];

    // Reference position: number of pairs advanced past (0,0); N*N means done.
    int k8 = 0;
    int k4 = 0;

    always #5 clk = ~clk;

    uv_index_sequencer #(.BLOCK_SIZE(8), .IDX_W(3)) dut8 (
        .clk(clk), .rst(rst), .restart(restart), .go(go),
        .u(u8), .v(v8), .last(last8), .done(done8)
    );

    uv_index_sequencer #(.BLOCK_SIZE(4), .IDX_W(2)) dut4 (
        .clk(clk), .rst(rst), .restart(restart), .go(go),
        .u(u4), .v(v4), .last(last4), .done(done4)
    );

    function automatic exp_t expect_of(int k, int n);
        exp_t e;
        if (k >= n * n) begin
            e.u = n - 1;
            e.v = n - 1;
            e.done = 1'b1;
        end else begin
            e.u = k / n;
            e.v = k % n;
            e.done = 1'b0;
        end
        e.last = (k == n * n - 1);
        return e;
    endfunction

    function automatic int next_k(int k, int n, bit r, bit rs, bit g);
        if (r || rs) return 0;
        if (g && k < n * n) return k + 1;
        return k;
    endfunction

    task automatic step(input bit r, input bit rs, input bit g);
        @(negedge clk);
        rst = r;
        restart = rs;
        go = g;
        k8 = next_k(k8, 8, r, rs, g);
        k4 = next_k(k4, 4, r, rs, g);
        q8.push_back(expect_of(k8, 8));
        q4.push_back(expect_of(k4, 4));
    endtask

    task automatic run_go(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q8.size() > 0) begin
            e = q8.pop_front();
            test_cnt++;
            if (int'(u8) != e.u || int'(v8) != e.v || done8 != e.done || last8 != e.last) begin
                fail_cnt++;
                $display("FAIL n8_state at %0t: got u=%0d v=%0d done=%0b last=%0b, want u=%0d v=%0d done=%0b last=%0b",
                         $time, u8, v8, done8, last8, e.u, e.v, e.done, e.last);
            end
        end
        if (q4.size() > 0) begin
            e = q4.pop_front();
            test_cnt++;
            if (int'(u4) != e.u || int'(v4) != e.v || done4 != e.done || last4 != e.last) begin
                fail_cnt++;
                $display("FAIL n4_state at %0t: got u=%0d v=%0d done=%0b last=%0b, want u=%0d v=%0d done=%0b last=%0b",
                         $time, u4, v4, done4, last4, e.u, e.v, e.done, e.last);
            end
        end
    end

    initial begin
        // Reset held two cycles with go high.
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        // Full sweep plus 10 go cycles while done.
        run_go(74);
        // Stall from (2,6).
        step(1'b0, 1'b1, 1'b0);
        run_go(22);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        // Restart beats go at (4,3).
        step(1'b0, 1'b1, 1'b0);
        run_go(35);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        // Restart after done, then a second full sweep.
        step(1'b0, 1'b1, 1'b0);
        run_go(66);
        step(1'b0, 1'b1, 1'b0);
        run_go(66);
        // Restart on the edge where done would rise.
        step(1'b0, 1'b1, 1'b0);
        run_go(63);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        // Mid-run reset at (5,5), then re-sweep.
        step(1'b0, 1'b1, 1'b0);
        run_go(45);
        step(1'b1, 1'b0, 1'b1);
        run_go(66);
        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 79) == 0),
                 ($urandom_range(0, 3) != 0));
        end
        step(1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        test_cnt++;
        if (q8.size() != 0 || q4.size() != 0) begin
            fail_cnt++;
            $display("FAIL queue_drain: got %0d/%0d pending, want 0/0", q8.size(), q4.size());
        end
        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
